// File: rtl/centroid_tracker_if.sv
// Pixel-stream inputs and per-frame result outputs of centroid_tracker, plus the FSM state for observation.
interface centroid_tracker_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int INTERNAL_WIDTH = 32
);
   localparam int CNT_WIDTH = INTERNAL_WIDTH - DATA_WIDTH;

   logic [DATA_WIDTH-1:0] data_in_x;
   logic [DATA_WIDTH-1:0] data_in_y;
   logic                  data_enable;
   logic                  data_end;
   logic                  busy;
   logic [DATA_WIDTH-1:0] centroid_x;
   logic [DATA_WIDTH-1:0] centroid_y;
   logic [DATA_WIDTH-1:0] bbox_min_x;
   logic [DATA_WIDTH-1:0] bbox_max_x;
   logic [DATA_WIDTH-1:0] bbox_min_y;
   logic [DATA_WIDTH-1:0] bbox_max_y;
   logic [CNT_WIDTH-1:0]  pixel_count;
   logic                  result_valid;
   logic                  done;
   logic [1:0]            state;

   // No back-pressure: a sample (data_enable) or frame end (data_end) is taken on any
   // cycle where busy=0 and silently dropped while busy=1; done is a one-cycle strobe.
   modport master (
      output data_in_x, data_in_y, data_enable, data_end,
      input  busy, centroid_x, centroid_y, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
      input  pixel_count, result_valid, done, state
   );

   modport slave (
      input  data_in_x, data_in_y, data_enable, data_end,
      output busy, centroid_x, centroid_y, bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y,
      output pixel_count, result_valid, done, state
   );
endinterface

// File: rtl/centroid_tracker.sv
// Per-frame centroid, bounding box and pixel count of a masked (x,y) stream,
// with quotients from two parallel one-bit-per-cycle restoring dividers.
module centroid_tracker #(
   parameter int DATA_WIDTH     = 8,
   parameter int INTERNAL_WIDTH = 32,
   parameter int MIN_COUNT      = 16
) (
   input logic            clk,
   input logic            rst,
   centroid_tracker_if.slave bus
);
   localparam int CNT_WIDTH = INTERNAL_WIDTH - DATA_WIDTH;
   localparam int STEP_W    = $clog2(INTERNAL_WIDTH);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [CNT_WIDTH-1:0] MIN_CNT   = CNT_WIDTH'(MIN_COUNT);
   localparam logic [STEP_W-1:0]    LAST_STEP = STEP_W'(INTERNAL_WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DIVIDE, S_DONE} state_t;

   state_t state, state_next;

   logic [INTERNAL_WIDTH-1:0] sum_x, sum_y, sum_x_nxt, sum_y_nxt;
   logic [CNT_WIDTH-1:0]      count, count_nxt;
   logic [DATA_WIDTH-1:0]     min_x, max_x, min_y, max_y;
   logic [DATA_WIDTH-1:0]     min_x_nxt, max_x_nxt, min_y_nxt, max_y_nxt;

   logic [STEP_W-1:0]         step;
   logic [INTERNAL_WIDTH-1:0] rem_x, rem_y, quo_x, quo_y, divisor;
   logic [INTERNAL_WIDTH:0]   shift_x, shift_y;
   logic                      take_x, take_y;
   logic                      valid_now;

   logic [DATA_WIDTH-1:0]     centroid_x, centroid_y;
   logic [DATA_WIDTH-1:0]     bbox_min_x, bbox_max_x, bbox_min_y, bbox_max_y;
   logic [CNT_WIDTH-1:0]      pixel_count;
   logic                      result_valid, done;

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE: begin
            if (bus.data_enable)   state_next = bus.data_end ? S_DIVIDE : S_ACCUM;
            else if (bus.data_end) state_next = S_DONE;
         end
         S_ACCUM:  if (bus.data_end) state_next = S_DIVIDE;
         S_DIVIDE: if (step == LAST_STEP) state_next = S_DONE;
         S_DONE:   state_next = S_IDLE;
         default:  state_next = S_IDLE;
      endcase
   end

   // Once the counter saturates the whole sample is dropped so sum/count stays a true mean.
   always_comb begin
      sum_x_nxt = sum_x;
      sum_y_nxt = sum_y;
      count_nxt = count;
      min_x_nxt = min_x;
      max_x_nxt = max_x;
      min_y_nxt = min_y;
      max_y_nxt = max_y;
      if (state == S_IDLE) begin
         if (bus.data_enable) begin
            sum_x_nxt = INTERNAL_WIDTH'(bus.data_in_x);
            sum_y_nxt = INTERNAL_WIDTH'(bus.data_in_y);
            count_nxt = CNT_WIDTH'(1);
            min_x_nxt = bus.data_in_x;
            max_x_nxt = bus.data_in_x;
            min_y_nxt = bus.data_in_y;
            max_y_nxt = bus.data_in_y;
         end else if (bus.data_end) begin
            count_nxt = '0;
         end
      end else if (state == S_ACCUM && bus.data_enable && count != CNT_MAX) begin
         sum_x_nxt = sum_x + INTERNAL_WIDTH'(bus.data_in_x);
         sum_y_nxt = sum_y + INTERNAL_WIDTH'(bus.data_in_y);
         count_nxt = count + CNT_WIDTH'(1);
         if (bus.data_in_x < min_x) min_x_nxt = bus.data_in_x;
         if (bus.data_in_x > max_x) max_x_nxt = bus.data_in_x;
         if (bus.data_in_y < min_y) min_y_nxt = bus.data_in_y;
         if (bus.data_in_y > max_y) max_y_nxt = bus.data_in_y;
      end
   end

   always_comb begin
      divisor   = INTERNAL_WIDTH'(count);
      shift_x   = {rem_x, quo_x[INTERNAL_WIDTH-1]};
      shift_y   = {rem_y, quo_y[INTERNAL_WIDTH-1]};
      take_x    = shift_x >= {1'b0, divisor};
      take_y    = shift_y >= {1'b0, divisor};
      valid_now = (count != '0) && ((MIN_COUNT == 0) || (count >= MIN_CNT));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         sum_x        <= '0;
         sum_y        <= '0;
         count        <= '0;
         min_x        <= '0;
         max_x        <= '0;
         min_y        <= '0;
         max_y        <= '0;
         step         <= '0;
         rem_x        <= '0;
         rem_y        <= '0;
         quo_x        <= '0;
         quo_y        <= '0;
         centroid_x   <= '0;
         centroid_y   <= '0;
         bbox_min_x   <= '0;
         bbox_max_x   <= '0;
         bbox_min_y   <= '0;
         bbox_max_y   <= '0;
         pixel_count  <= '0;
         result_valid <= 1'b0;
         done         <= 1'b0;
      end else begin
         state <= state_next;
         sum_x <= sum_x_nxt;
         sum_y <= sum_y_nxt;
         count <= count_nxt;
         min_x <= min_x_nxt;
         max_x <= max_x_nxt;
         min_y <= min_y_nxt;
         max_y <= max_y_nxt;
         // Dividends load from the next-sum values so a sample on the data_end cycle is included.
         if (state != S_DIVIDE && state_next == S_DIVIDE) begin
            rem_x <= '0;
            rem_y <= '0;
            quo_x <= sum_x_nxt;
            quo_y <= sum_y_nxt;
            step  <= '0;
         end else if (state == S_DIVIDE) begin
            rem_x <= take_x ? (shift_x[INTERNAL_WIDTH-1:0] - divisor) : shift_x[INTERNAL_WIDTH-1:0];
            rem_y <= take_y ? (shift_y[INTERNAL_WIDTH-1:0] - divisor) : shift_y[INTERNAL_WIDTH-1:0];
            quo_x <= {quo_x[INTERNAL_WIDTH-2:0], take_x};
            quo_y <= {quo_y[INTERNAL_WIDTH-2:0], take_y};
            step  <= step + STEP_W'(1);
         end
         done <= (state == S_DONE);
         if (state == S_DONE) begin
            pixel_count  <= count;
            result_valid <= valid_now;
            centroid_x   <= valid_now ? quo_x[DATA_WIDTH-1:0] : '0;
            centroid_y   <= valid_now ? quo_y[DATA_WIDTH-1:0] : '0;
            bbox_min_x   <= valid_now ? min_x : '0;
            bbox_max_x   <= valid_now ? max_x : '0;
            bbox_min_y   <= valid_now ? min_y : '0;
            bbox_max_y   <= valid_now ? max_y : '0;
         end
      end
   end

   assign bus.busy         = (state == S_DIVIDE) || (state == S_DONE);
   assign bus.state        = state;
   assign bus.centroid_x   = centroid_x;
   assign bus.centroid_y   = centroid_y;
   assign bus.bbox_min_x   = bbox_min_x;
   assign bus.bbox_max_x   = bbox_max_x;
   assign bus.bbox_min_y   = bbox_min_y;
   assign bus.bbox_max_y   = bbox_max_y;
   assign bus.pixel_count  = pixel_count;
   assign bus.result_valid = result_valid;
   assign bus.done         = done;
endmodule

// File: tb/tb_centroid_tracker.sv
// Bench for centroid_tracker: two instances (MIN_COUNT 0 and 16) fed the same frames,
// each scored against its own queue of expected per-frame results.
module tb_centroid_tracker;
   localparam int DW = 8;
   localparam int IW = 32;

   typedef struct {
      int cyc;
      int cx, cy, mnx, mxx, mny, mxy, cnt;
      bit vld;
   } exp_t;

   typedef struct {
      int nd, rep;
      int x0, y0, x1, y1, x2, y2;
      bit end_sep;
      int junk;
      exp_t raw;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t q0[$];
   exp_t q1[$];
   exp_t e0, e1;
   int   fx[64];
   int   fy[64];
   vec_t vec[8];

   centroid_tracker_if #(.DATA_WIDTH(DW), .INTERNAL_WIDTH(IW)) if0 ();
   centroid_tracker_if #(.DATA_WIDTH(DW), .INTERNAL_WIDTH(IW)) if1 ();

   centroid_tracker #(.DATA_WIDTH(DW), .INTERNAL_WIDTH(IW), .MIN_COUNT(0)) dut0 (
      .clk(clk), .rst(rst), .bus(if0.slave));
   centroid_tracker #(.DATA_WIDTH(DW), .INTERNAL_WIDTH(IW), .MIN_COUNT(16)) dut1 (
      .clk(clk), .rst(rst), .bus(if1.slave));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, want);
      end
   endtask

   function automatic exp_t mk_exp(input exp_t raw, input int minc, input int c);
      exp_t e;
      e = raw;
      e.vld = (raw.cnt != 0) && (raw.cnt >= minc);
      if (!e.vld) begin
         e.cx = 0; e.cy = 0; e.mnx = 0; e.mxx = 0; e.mny = 0; e.mxy = 0;
      end
      e.cyc = c + 1 + ((raw.cnt == 0) ? 1 : IW + 1);
      return e;
   endfunction

   function automatic exp_t model(input int n);
      exp_t r;
      int sx, sy;
      r = '{default: 0};
      sx = 0; sy = 0;
      r.mnx = 255; r.mny = 255;
      for (int i = 0; i < n; i++) begin
         sx += fx[i];
         sy += fy[i];
         if (fx[i] < r.mnx) r.mnx = fx[i];
         if (fx[i] > r.mxx) r.mxx = fx[i];
         if (fy[i] < r.mny) r.mny = fy[i];
         if (fy[i] > r.mxy) r.mxy = fy[i];
      end
      r.cx = sx / n;
      r.cy = sy / n;
      r.cnt = n;
      return r;
   endfunction

   task automatic score(input string tag, input exp_t e, input int acyc,
                        input logic [DW-1:0] cx, input logic [DW-1:0] cy,
                        input logic [DW-1:0] mnx, input logic [DW-1:0] mxx,
                        input logic [DW-1:0] mny, input logic [DW-1:0] mxy,
                        input logic [IW-DW-1:0] cnt, input logic vld);
      chk({tag, ".done_cycle"}, acyc, e.cyc);
      chk({tag, ".centroid_x"}, 32'(cx), e.cx);
      chk({tag, ".centroid_y"}, 32'(cy), e.cy);
      chk({tag, ".bbox_min_x"}, 32'(mnx), e.mnx);
      chk({tag, ".bbox_max_x"}, 32'(mxx), e.mxx);
      chk({tag, ".bbox_min_y"}, 32'(mny), e.mny);
      chk({tag, ".bbox_max_y"}, 32'(mxy), e.mxy);
      chk({tag, ".pixel_count"}, 32'(cnt), e.cnt);
      chk({tag, ".result_valid"}, 32'(vld), 32'(e.vld));
   endtask

   always @(negedge clk) begin
      if (if0.done === 1'b1) begin
         chk("dut0.done_expected", 32'(q0.size() != 0), 1);
         if (q0.size() != 0) begin
            e0 = q0.pop_front();
            score("dut0", e0, cyc, if0.centroid_x, if0.centroid_y, if0.bbox_min_x, if0.bbox_max_x,
                  if0.bbox_min_y, if0.bbox_max_y, if0.pixel_count, if0.result_valid);
         end
      end
      if (if1.done === 1'b1) begin
         chk("dut1.done_expected", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) begin
            e1 = q1.pop_front();
            score("dut1", e1, cyc, if1.centroid_x, if1.centroid_y, if1.bbox_min_x, if1.bbox_max_x,
                  if1.bbox_min_y, if1.bbox_max_y, if1.pixel_count, if1.result_valid);
         end
      end
   end

   task automatic drive(input int x, input int y, input bit en, input bit fend);
      @(posedge clk);
      #1;
      if0.data_in_x = DW'(x);   if1.data_in_x = DW'(x);
      if0.data_in_y = DW'(y);   if1.data_in_y = DW'(y);
      if0.data_enable = en;     if1.data_enable = en;
      if0.data_end = fend;      if1.data_end = fend;
   endtask

   task automatic push_exp(input exp_t raw);
      q0.push_back(mk_exp(raw, 0, cyc));
      q1.push_back(mk_exp(raw, 16, cyc));
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         @(negedge clk);
         if (k == 0) begin
            chk("dut0.busy_after_end", 32'(if0.busy), 1);
            chk("dut1.busy_after_end", 32'(if1.busy), 1);
         end
         if (if0.done === 1'b1) seen = 1'b1;
      end
      chk("done_within_budget", 32'(seen), 1);
   endtask

   // Drives fx/fy[0..n-1] with random idle gaps; the expected result is queued on the end cycle.
   task automatic run_frame(input int n, input bit end_sep, input int junk, input bit push, input exp_t raw);
      bit last;
      for (int i = 0; i < n; i++) begin
         if (i > 0) repeat ($urandom_range(0, 2)) drive(0, 0, 1'b0, 1'b0);
         last = (i == n - 1) && !end_sep;
         @(posedge clk);
         #1;
         if (last && push) push_exp(raw);
         if0.data_in_x = DW'(fx[i]);   if1.data_in_x = DW'(fx[i]);
         if0.data_in_y = DW'(fy[i]);   if1.data_in_y = DW'(fy[i]);
         if0.data_enable = 1'b1;       if1.data_enable = 1'b1;
         if0.data_end = last;          if1.data_end = last;
      end
      if (n == 0 || end_sep) begin
         @(posedge clk);
         #1;
         if (push) push_exp(raw);
         if0.data_enable = 1'b0;  if1.data_enable = 1'b0;
         if0.data_end = 1'b1;     if1.data_end = 1'b1;
      end
      for (int j = 0; j < junk; j++) drive(200, 200, 1'b1, 1'b0);
      drive(0, 0, 1'b0, 1'b0);
      if (push) wait_done();
   endtask

   task automatic set_vec(input int i, input int nd, input int rep,
                          input int x0, input int y0, input int x1, input int y1, input int x2, input int y2,
                          input bit end_sep, input int junk,
                          input int cx, input int cy, input int mnx, input int mxx,
                          input int mny, input int mxy, input int cnt);
      vec[i] = '{nd: nd, rep: rep, x0: x0, y0: y0, x1: x1, y1: y1, x2: x2, y2: y2,
                 end_sep: end_sep, junk: junk,
                 raw: '{cyc: 0, cx: cx, cy: cy, mnx: mnx, mxx: mxx, mny: mny, mxy: mxy, cnt: cnt, vld: 1'b0}};
   endtask

   task automatic run_vec(input int i);
      int k;
      int px[3];
      int py[3];
      px[0] = vec[i].x0; px[1] = vec[i].x1; px[2] = vec[i].x2;
      py[0] = vec[i].y0; py[1] = vec[i].y1; py[2] = vec[i].y2;
      k = 0;
      for (int d = 0; d < vec[i].nd; d++)
         for (int r = 0; r < vec[i].rep; r++) begin
            fx[k] = px[d];
            fy[k] = py[d];
            k++;
         end
      run_frame(k, vec[i].end_sep, vec[i].junk, 1'b1, vec[i].raw);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, ".dut0.busy"}, 32'(if0.busy), 0);
      chk({tag, ".dut0.done"}, 32'(if0.done), 0);
      chk({tag, ".dut0.state"}, 32'(if0.state), 0);
      chk({tag, ".dut0.centroid_x"}, 32'(if0.centroid_x), 0);
      chk({tag, ".dut0.bbox_max_y"}, 32'(if0.bbox_max_y), 0);
      chk({tag, ".dut0.pixel_count"}, 32'(if0.pixel_count), 0);
      chk({tag, ".dut0.result_valid"}, 32'(if0.result_valid), 0);
      chk({tag, ".dut1.busy"}, 32'(if1.busy), 0);
      chk({tag, ".dut1.pixel_count"}, 32'(if1.pixel_count), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t none;
      int n;
      none = '{default: 0};
      //       i  nd rep  x0  y0  x1  y1  x2  y2 sep junk  cx  cy mnx mxx mny mxy cnt
      set_vec(0, 3, 1,  10, 20, 12, 22, 14, 24, 0, 0,   12, 22, 10, 14, 20, 24, 3);
      set_vec(1, 0, 0,   0,  0,  0,  0,  0,  0, 1, 0,    0,  0,  0,  0,  0,  0, 0);
      set_vec(2, 1, 15, 100, 50, 0,  0,  0,  0, 1, 0,  100, 50,100,100, 50, 50, 15);
      set_vec(3, 1, 16, 100, 50, 0,  0,  0,  0, 0, 0,  100, 50,100,100, 50, 50, 16);
      set_vec(4, 3, 1,   0,  0,255,255,  1,  0, 0, 0,   85, 85,  0,255,  0,255, 3);
      set_vec(5, 1, 1, 255,  0,  0,  0,  0,  0, 0, 0,  255,  0,255,255,  0,  0, 1);
      set_vec(6, 2, 1,   3,  7,  4,  8,  0,  0, 1, 20,   3,  7,  3,  4,  7,  8, 2);
      set_vec(7, 3, 1,  40, 60, 42, 61, 41, 65, 0, 25,  41, 62, 40, 42, 60, 65, 3);

      if0.data_in_x = '0; if0.data_in_y = '0; if0.data_enable = 1'b0; if0.data_end = 1'b0;
      if1.data_in_x = '0; if1.data_in_y = '0; if1.data_enable = 1'b0; if1.data_end = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset_outputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(i);

      for (int f = 0; f < 4; f++) begin
         n = $urandom_range(1, 24);
         for (int i = 0; i < n; i++) begin
            fx[i] = $urandom_range(0, 255);
            fy[i] = $urandom_range(0, 255);
         end
         run_frame(n, 1'(f % 2), 0, 1'b1, model(n));
      end

      // Abort a frame partway through the divide; nothing is queued for it.
      fx[0] = 5; fy[0] = 5; fx[1] = 7; fy[1] = 9;
      run_frame(2, 1'b0, 0, 1'b0, none);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_reset_outputs("mid_divide_reset");
      repeat (45) drive(0, 0, 1'b0, 1'b0);

      run_vec(0);
      run_vec(4);

      repeat (5) @(posedge clk);
      chk("dut0.queue_drained", q0.size(), 0);
      chk("dut1.queue_drained", q1.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
